// File: rtl/masked_sbox_pkg.sv
// rtl/masked_sbox_pkg.sv - shared types and helpers for the masked S-box layer
package masked_sbox_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} layer_state_t;

   function automatic int calc_nb(input int nlanes, input int npar);
      return nlanes / npar;
   endfunction

   function automatic int calc_bw(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   // Bit offset of nibble 'lane' of share 'share' in a flattened shared state.
   function automatic int lane_lsb(input int share, input int lane, input int nlanes);
      return (share * nlanes + lane) * NIBBLE_W;
   endfunction
endpackage

// File: rtl/masked_sbox_core.sv
// rtl/masked_sbox_core.sv - masked 4-bit Skinny S-box core, LATENCY register stages
module masked_sbox_core
   import masked_sbox_pkg::*;
#(
   parameter int SHARES  = 2,
   parameter int LATENCY = 2,
   parameter int RAND_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SHARES*NIBBLE_W-1:0]   x,
   input  logic [RAND_W-1:0]            rnd,
   output logic [SHARES*NIBBLE_W-1:0]   y
);
   localparam logic [63:0] S4_TAB = 64'hF7E4D583B2A1096C;
   localparam int RN = RAND_W / NIBBLE_W;
   localparam int RS = (SHARES > 1) ? SHARES - 1 : 1;

   logic [NIBBLE_W-1:0]        v;
   logic [NIBBLE_W-1:0]        acc;
   logic [SHARES*NIBBLE_W-1:0] fresh;
   logic [SHARES*NIBBLE_W-1:0] pipe [LATENCY];

   // Shares meet only here; the result leaves re-split under all fresh random nibbles.
   always_comb begin
      v = '0;
      for (int s = 0; s < SHARES; s++) v = v ^ x[s*NIBBLE_W +: NIBBLE_W];
      acc   = S4_TAB[{v, 2'b00} +: NIBBLE_W];
      fresh = '0;
      for (int j = 0; j < RN; j++)
         fresh[(j % RS)*NIBBLE_W +: NIBBLE_W] = fresh[(j % RS)*NIBBLE_W +: NIBBLE_W]
                                                ^ rnd[j*NIBBLE_W +: NIBBLE_W];
      for (int s = 0; s < SHARES - 1; s++) acc = acc ^ fresh[s*NIBBLE_W +: NIBBLE_W];
      fresh[(SHARES-1)*NIBBLE_W +: NIBBLE_W] = acc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= fresh;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign y = pipe[LATENCY-1];
endmodule

// File: rtl/masked_sbox_layer_ctrl.sv
// rtl/masked_sbox_layer_ctrl.sv - layer FSM, batch/wait/done counters; optional SBOX_LAYER_SHUFFLE_EN
module masked_sbox_layer_ctrl
   import masked_sbox_pkg::*;
#(
   parameter int NB      = 4,
   parameter int BW      = 2,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
`ifdef SBOX_LAYER_SHUFFLE_EN
   input  logic [BW-1:0] shuffle_seed,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          rnd_valid,
   output logic          rnd_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic [BW-1:0] batch,
   output logic          load,
   output logic          issue,
   output logic          capt
);
   localparam int WW = $clog2(LATENCY) + 1;
   localparam logic [WW-1:0] WAIT_LAST  = WW'(LATENCY - 1);
   localparam logic [BW-1:0] BATCH_LAST = BW'(NB - 1);
   localparam logic [BW:0]   DONE_LAST  = (BW+1)'(NB - 1);

   layer_state_t  state, state_nxt;
   logic [WW-1:0] wait_cnt;
   logic [BW:0]   done_cnt;
   logic [BW-1:0] start;
   logic          last;

`ifdef SBOX_LAYER_SHUFFLE_EN
   localparam logic [BW:0] NB_W = (BW+1)'(NB);
   // seed < 2^BW < 2*NB, so one conditional subtraction reduces it modulo NB.
   assign start = ({1'b0, shuffle_seed} >= NB_W) ? shuffle_seed - NB_W[BW-1:0] : shuffle_seed;
`else
   assign start = '0;
`endif

   assign last = (done_cnt == DONE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = ISSUE;
         ISSUE:   if (rnd_valid) state_nxt = WAIT;
         WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAPT;
         CAPT:    state_nxt = last ? DONE : ISSUE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      load      = 1'b0;
      issue     = 1'b0;
      capt      = 1'b0;
      case (state)
         IDLE:    begin in_ready = 1'b1; busy = 1'b0; load = in_valid; end
         ISSUE:   begin rnd_ready = 1'b1; issue = rnd_valid; end
         CAPT:    capt = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         batch    <= '0;
         wait_cnt <= '0;
         done_cnt <= '0;
      end else begin
         if (load) begin
            batch    <= start;
            done_cnt <= '0;
         end
         if (issue)              wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (capt) begin
            batch    <= (batch == BATCH_LAST) ? '0 : batch + 1'b1;
            done_cnt <= done_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/masked_sbox_layer_seq.sv
// rtl/masked_sbox_layer_seq.sv - serialised masked Skinny-64 S-box layer; optional SBOX_LAYER_SHUFFLE_EN
module masked_sbox_layer_seq
   import masked_sbox_pkg::*;
#(
   parameter int NLANES  = 16,
   parameter int NPAR    = 4,
   parameter int SHARES  = 2,
   parameter int LATENCY = 2,
   parameter int RAND_W  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
`ifdef SBOX_LAYER_SHUFFLE_EN
   input  logic [calc_bw(calc_nb(NLANES, NPAR))-1:0] shuffle_seed,
`endif
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [SHARES*NLANES*NIBBLE_W-1:0] in_data,
   input  logic                              rnd_valid,
   output logic                              rnd_ready,
   input  logic [NPAR*RAND_W-1:0]            rnd_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SHARES*NLANES*NIBBLE_W-1:0] out_data,
   output logic                              busy
);
   localparam int NB = calc_nb(NLANES, NPAR);
   localparam int BW = calc_bw(NB);
   localparam int CW = SHARES * NIBBLE_W;

   logic [SHARES*NLANES*NIBBLE_W-1:0] in_buf, out_buf;
   logic [NPAR*RAND_W-1:0]            rnd_buf;
   logic [CW-1:0]                     core_x [NPAR];
   logic [CW-1:0]                     core_y [NPAR];
   logic [BW-1:0]                     batch;
   logic                              load, issue, capt;

   masked_sbox_layer_ctrl #(.NB(NB), .BW(BW), .LATENCY(LATENCY)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
`ifdef SBOX_LAYER_SHUFFLE_EN
      .shuffle_seed (shuffle_seed),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .batch     (batch),
      .load      (load),
      .issue     (issue),
      .capt      (capt)
   );

   // Core inputs come only from registers and are zeroed between batches and
   // outside a layer so that stale shares never sit next to fresh ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_buf  <= '0;
         out_buf <= '0;
         rnd_buf <= '0;
         for (int k = 0; k < NPAR; k++) core_x[k] <= '0;
      end else begin
         if (load) in_buf <= in_data;
         if (issue) begin
            rnd_buf <= rnd_data;
            for (int k = 0; k < NPAR; k++)
               for (int s = 0; s < SHARES; s++)
                  core_x[k][s*NIBBLE_W +: NIBBLE_W] <=
                     in_buf[lane_lsb(s, int'(batch) * NPAR + k, NLANES) +: NIBBLE_W];
         end else if (capt) begin
            for (int k = 0; k < NPAR; k++) core_x[k] <= '0;
         end
         if (capt) begin
            for (int k = 0; k < NPAR; k++)
               for (int s = 0; s < SHARES; s++)
                  out_buf[lane_lsb(s, int'(batch) * NPAR + k, NLANES) +: NIBBLE_W] <=
                     core_y[k][s*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   for (genvar k = 0; k < NPAR; k++) begin : g_core
      masked_sbox_core #(.SHARES(SHARES), .LATENCY(LATENCY), .RAND_W(RAND_W)) u_core (
         .clk (clk),
         .rst (rst),
         .x   (core_x[k]),
         .rnd (rnd_buf[k*RAND_W +: RAND_W]),
         .y   (core_y[k])
      );
   end

   assign out_data = out_buf;
endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// tb/tb_masked_sbox_layer_seq.sv - randomized self-checking bench for masked_sbox_layer_seq
module tb_masked_sbox_layer_seq;
   localparam int W = 128;
   localparam logic [3:0] SKINNY_S4 [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                             4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
   localparam int NB_T  [3] = '{4, 1, 16};
   localparam int LAT_T [3] = '{2, 3, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [W-1:0]   in_data;
   logic [255:0]   rnd_data;
   logic           in_valid, rnd_valid, out_ready;
   logic           in_ready, rnd_ready, out_valid, busy;
   logic [W-1:0]   out_data;
   int             sel = 0;
`ifdef SBOX_LAYER_SHUFFLE_EN
   logic [3:0]     seed = '0;
`endif

   logic           in_valid_v [3], rnd_valid_v [3], out_ready_v [3];
   logic           in_ready_v [3], rnd_ready_v [3], out_valid_v [3], busy_v [3];
   logic [W-1:0]   out_data_v [3];

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         in_valid_v[i]  = (sel == i) && in_valid;
         rnd_valid_v[i] = (sel == i) && rnd_valid;
         out_ready_v[i] = (sel == i) && out_ready;
      end
      in_ready  = in_ready_v[sel];
      rnd_ready = rnd_ready_v[sel];
      out_valid = out_valid_v[sel];
      busy      = busy_v[sel];
      out_data  = out_data_v[sel];
   end

   masked_sbox_layer_seq dut0 (
      .clk(clk), .rst(rst),
`ifdef SBOX_LAYER_SHUFFLE_EN
      .shuffle_seed(seed[1:0]),
`endif
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data),
      .rnd_valid(rnd_valid_v[0]), .rnd_ready(rnd_ready_v[0]), .rnd_data(rnd_data[63:0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
      .busy(busy_v[0]));

   masked_sbox_layer_seq #(.NPAR(16), .LATENCY(3)) dut1 (
      .clk(clk), .rst(rst),
`ifdef SBOX_LAYER_SHUFFLE_EN
      .shuffle_seed(seed[0:0]),
`endif
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data),
      .rnd_valid(rnd_valid_v[1]), .rnd_ready(rnd_ready_v[1]), .rnd_data(rnd_data),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
      .busy(busy_v[1]));

   masked_sbox_layer_seq #(.NPAR(1)) dut2 (
      .clk(clk), .rst(rst),
`ifdef SBOX_LAYER_SHUFFLE_EN
      .shuffle_seed(seed),
`endif
      .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_data(in_data),
      .rnd_valid(rnd_valid_v[2]), .rnd_ready(rnd_ready_v[2]), .rnd_data(rnd_data[15:0]),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_data(out_data_v[2]),
      .busy(busy_v[2]));

   int errors = 0;
   int checks = 0;

   int          r_lat;
   logic [63:0] r_res;
   bit          r_stable, r_idle_after, r_start_ok, r_busy_mid;

   function automatic logic [63:0] model(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = SKINNY_S4[v[4*i +: 4]];
      return r;
   endfunction

   function automatic int exp_lat(input int s, input int gap);
      return 1 + NB_T[s] * (LAT_T[s] + 2) + gap;
   endfunction

   function automatic logic [255:0] rnd_rand();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one layer on the selected instance; timing is counted in negedges after the handshake.
   task automatic run_layer(input logic [63:0] value, input int gap_len, input int hold, input bit junk);
      logic [63:0] m;
      logic [W-1:0] snap;
      int n, hs, gap;
      bit timeout;
      m = {$urandom, $urandom};
      timeout = 0; r_stable = 1; r_busy_mid = 0;
      @(negedge clk);
      r_start_ok = in_ready;
      in_data = {m, m ^ value};
      in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0; rnd_data = rnd_rand();
      n = 0; hs = 0; gap = 0;
      forever begin
         @(negedge clk);
         n++;
         if (n == 1) r_busy_mid = busy;
         if (out_valid) break;
         if (n > 400) begin timeout = 1; break; end
         in_valid  = junk;
         in_data   = junk ? {$urandom, $urandom, $urandom, $urandom} : '0;
         out_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
         rnd_data  = rnd_rand();
         if (hs == 2 && gap < gap_len) begin
            rnd_valid = 1'b0;
            if (rnd_ready) gap++;
         end else begin
            rnd_valid = 1'b1;
         end
         if (rnd_valid && rnd_ready) hs++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      r_lat = timeout ? -1 : n;
      snap  = out_data;
      r_res = snap[127:64] ^ snap[63:0];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) r_stable = 0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      r_idle_after = (in_ready === 1'b1) && (out_valid === 1'b0) && (busy === 1'b0);
   endtask

   task automatic test_reset();
      #12;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", s, in_ready); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, out_valid); end
         checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready[%0d]: got %b want 0", s, rnd_ready); end
         checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy); end
         checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", s, out_data); end
      end
      sel = 0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_identity_ramp();
      logic [63:0] v;
      v = 64'hFEDCBA9876543210;
      sel = 0;
      run_layer(v, 0, 0, 0);
      checks++; if (r_start_ok !== 1'b1) begin errors++; $display("FAIL ramp_in_ready: got %b want 1", r_start_ok); end
      checks++; if (r_busy_mid !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b want 1", r_busy_mid); end
      checks++; if (r_lat != 17) begin errors++; $display("FAIL ramp_latency: got %0d want 17", r_lat); end
      checks++; if (r_res !== 64'hF7E4D583B2A1096C) begin errors++; $display("FAIL ramp_value: got %h want F7E4D583B2A1096C", r_res); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL ramp_model: got %h want %h", r_res, model(v)); end
      checks++; if (r_idle_after !== 1'b1) begin errors++; $display("FAIL ramp_idle_after: got %b want 1", r_idle_after); end
   endtask

   task automatic test_random_ignored_inputs();
      logic [63:0] v;
      sel = 0;
      for (int i = 0; i < 4; i++) begin
         v = {$urandom, $urandom};
         run_layer(v, 0, 0, 1);
         checks++; if (r_lat != exp_lat(0, 0)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, r_lat, exp_lat(0, 0)); end
         checks++; if (r_res !== model(v)) begin errors++; $display("FAIL rand_value[%0d]: got %h want %h", i, r_res, model(v)); end
      end
   endtask

   task automatic test_rnd_starvation();
      logic [63:0] v;
      v = {$urandom, $urandom};
      sel = 0;
      run_layer(v, 5, 0, 0);
      checks++; if (r_lat != 22) begin errors++; $display("FAIL starve_latency: got %0d want 22", r_lat); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL starve_value: got %h want %h", r_res, model(v)); end
   endtask

   task automatic test_backpressure();
      logic [63:0] v;
      v = {$urandom, $urandom};
      sel = 0;
      run_layer(v, 0, 10, 0);
      checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", r_stable); end
      checks++; if (r_idle_after !== 1'b1) begin errors++; $display("FAIL bp_idle_after: got %b want 1", r_idle_after); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL bp_value: got %h want %h", r_res, model(v)); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] v;
      sel = 0;
      @(negedge clk);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0;
      repeat (6) begin @(negedge clk); in_valid = 1'b0; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      #2 rst = 1'b0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== '0)    begin errors++; $display("FAIL mid_out_data: got %h want 0", out_data); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      @(negedge clk); rst = 1'b1;
      v = {$urandom, $urandom};
      run_layer(v, 0, 0, 0);
      checks++; if (r_lat != 17) begin errors++; $display("FAIL mid_fresh_latency: got %0d want 17", r_lat); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL mid_fresh_value: got %h want %h", r_res, model(v)); end
   endtask

   task automatic test_param_sweep();
      logic [63:0] v;
      for (int s = 1; s < 3; s++) begin
         sel = s;
         v = {$urandom, $urandom};
         run_layer(v, 0, 0, 0);
         checks++; if (r_lat != exp_lat(s, 0)) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", s, r_lat, exp_lat(s, 0)); end
         checks++; if (r_res !== model(v)) begin errors++; $display("FAIL sweep_value[%0d]: got %h want %h", s, r_res, model(v)); end
      end
      sel = 0;
   endtask

`ifdef SBOX_LAYER_SHUFFLE_EN
   task automatic test_shuffle();
      logic [63:0] v;
      v = 64'hFEDCBA9876543210;
      sel = 0; seed = 4'd3;
      run_layer(v, 0, 0, 0);
      checks++; if (r_lat != 17) begin errors++; $display("FAIL shuffle_latency: got %0d want 17", r_lat); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL shuffle_value: got %h want %h", r_res, model(v)); end
      sel = 2; seed = 4'($urandom_range(0, 15));
      v = {$urandom, $urandom};
      run_layer(v, 0, 0, 0);
      checks++; if (r_lat != exp_lat(2, 0)) begin errors++; $display("FAIL shuffle16_latency: got %0d want %0d", r_lat, exp_lat(2, 0)); end
      checks++; if (r_res !== model(v)) begin errors++; $display("FAIL shuffle16_value: got %h want %h", r_res, model(v)); end
      sel = 0; seed = '0;
   endtask
`endif

   initial begin
      rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; rnd_data = '0;
      test_reset();
      test_identity_ramp();
      test_random_ignored_inputs();
      test_rnd_starvation();
      test_backpressure();
      test_reset_mid();
      test_param_sweep();
`ifdef SBOX_LAYER_SHUFFLE_EN
      test_shuffle();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/masked_sbox_layer_seq.md
Name: masked_sbox_layer_seq

Overview:
- Serialised, parametrised masked Skinny-64 S-box layer.
- Accepts a full shared state of NLANES nibbles and pushes it through NPAR instances of the existing masked 4-bit S-box core, NPAR lanes per batch.
- Holds shared inputs and fresh randomness stable for the core latency, then collects the shared outputs.
- Successor to the single fixed S-box with free-running clock-gate controller: adds width, parallelism, latency and share-count generalisation plus valid/ready handshakes on data and randomness.

Parameters:
- NLANES, 16, nibbles per state; must be a multiple of NPAR.
- NPAR, 4, masked S-box core instances operating in parallel.
- SHARES, 2, Boolean shares per bit (order + 1).
- LATENCY, 2, core latency in cycles; core inputs held constant this long.
- RAND_W, 16, fresh random bits per core per batch.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  state offered
- in_ready  out  1  block can accept state
- in_data  in  SHARES*NLANES*4  share s at [s*NLANES*4 +: NLANES*4]; lane i of a share at [4i+3:4i]
- rnd_valid  in  1  fresh randomness offered
- rnd_ready  out  1  randomness consumed this cycle when rnd_valid is high
- rnd_data  in  NPAR*RAND_W  core k uses [k*RAND_W +: RAND_W]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  SHARES*NLANES*4  shared result, same layout as in_data
- busy  out  1  high in every state except IDLE

Behaviour:
- Derived: NB = NLANES/NPAR batches; BW = clog2(NB), minimum 1.
- Reset (rst low, asynchronous) clears all registers:
  - state = IDLE; input, output and randomness buffers = 0; counters = 0.
  - in_ready=1, out_valid=0, rnd_ready=0, busy=0, out_data=0.
  - Assertion mid-operation aborts the layer; no partial result is ever presented.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_data, batch=0 (or start offset, see Optional Feature), go to ISSUE.
  - ISSUE: rnd_ready=1. Stall while rnd_valid=0. On rnd_valid, latch rnd_data, drive the selected NPAR lanes of every share to the cores, wait_cnt=0, go to WAIT.
  - WAIT: core inputs and latched randomness held constant; wait_cnt increments each cycle; after LATENCY cycles go to CAPT.
  - CAPT: write core outputs into the out buffer for the current batch lanes. If this was the NB-th batch go to DONE, else batch=batch+1 (mod NB) and go to ISSUE.
  - DONE: out_valid=1; out_data stable until out_valid & out_ready, then IDLE. in_ready=0 in DONE; no bypass.
- Latency with rnd_valid held high:
  - Input handshake in cycle t gives out_valid first high in cycle t+1+NB*(LATENCY+2).
  - Defaults: t+17.
  - Each cycle with rnd_valid low in ISSUE adds one cycle.
- Core inputs are driven only from registers (no combinational path from in_data, rnd_data).
- Core inputs are zero in IDLE and DONE to avoid share recombination glitches.
- Batch counter wraps from NB-1 to 0. A completed-batch counter of width BW+1 terminates the layer, independent of the start batch.
- Simultaneous events:
  - out_ready high outside DONE is ignored.
  - in_valid outside IDLE is ignored; in_data is not sampled.
- Values are never unmasked internally; shares are only combined inside the cores.

Optional Feature:
- Macro SBOX_LAYER_SHUFFLE_EN.
- Defined:
  - Extra input port shuffle_seed, width BW, sampled at the input handshake.
  - Processing starts at batch shuffle_seed and wraps modulo NB. Every batch is processed exactly once; latency is unchanged.
  - Each batch's lanes are still written to their own positions, so the result is order-independent.
- Undefined: no port; batches run 0..NB-1.

Decomposition:
- Package masked_sbox_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, CAPT, DONE);
  - NIBBLE_W=4;
  - function for batch count / BW;
  - lane-slice helper function.
- Sub-module masked_sbox_layer_ctrl holds the FSM, batch/wait/done counters and handshakes, and emits batch index, issue strobe and capture strobe.
- The top instantiates the controller, the buffers and NPAR existing masked S-box cores.

Test Plan:
- Identity ramp:
  - Stimulus: unmasked lanes 0xFEDCBA9876543210, share1 random, share0 = share1 ^ value; defaults; rnd_valid constantly high.
  - Response: out shares XOR to 0xF7E4D583B2A1096C; out_valid exactly 17 cycles after the input handshake.
- Randomness starvation:
  - Stimulus: drop rnd_valid for 5 cycles before batch 2.
  - Response: latency 22; result unchanged.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles.
  - Response: out_data stable, in_ready=0; IDLE on the cycle after out_ready rises.
- Reset mid-layer:
  - Stimulus: pull rst low during WAIT of batch 1, then release.
  - Response: out_valid=0, out_data=0, in_ready=1; a fresh layer then completes correctly.
- Parameter sweep:
  - Stimulus: NPAR=16, LATENCY=3; then NPAR=1.
  - Response: latency 1+1*5=6 and 1+16*4=65 respectively; correct values.
- SBOX_LAYER_SHUFFLE_EN with shuffle_seed=3:
  - Response: cores see batch order 3,0,1,2; result equals the unshuffled result.
